uart_tx_top: RTL and testbench
==============================

// Module: uart_tx_top
// PURPOSE
//   Parallel-in, serial-out UART transmitter, one bit per clk (no baud divider).
//   Sends start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
//   Built from a frame FSM, a shift serializer, a parity calculator and an output mux.
//   Sits between the host datapath and the serial TX pin.
// PARAMETERS
//   DATA_WIDTH  8  width of P_DATA and number of data bits per frame
// PORTS
//   clk         in   1           system clock; all state changes on its rising edge
//   rst         in   1           asynchronous, active-low reset
//   P_DATA      in   DATA_WIDTH  parallel byte to send; sampled when Data_Valid is accepted
//   Data_Valid  in   1           one-cycle request strobe to send P_DATA
//   Par_EN      in   1           1 = insert parity bit; sampled with P_DATA
//   Par_TYP     in   1           0 = even parity, 1 = odd parity; sampled with P_DATA
//   Tx_out      out  1           serial line; idle level 1
//   busy        out  1           1 while a frame is in progress
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, Tx_out=1, busy=0, shift reg/parity/counter cleared.
//   - States: IDLE, START, DATA, PARITY, STOP. Tx_out is decoded from the current state:
//     IDLE=1, START=0, DATA=shift_reg[0], PARITY=par_bit, STOP=1.
//   - Accept: on a rising edge with Data_Valid=1 while state is IDLE or STOP.
//     Latch P_DATA, Par_EN, Par_TYP; next state START.
//   - Data_Valid in START/DATA/PARITY is ignored (no queueing, no error).
//   - Latency: start bit appears on Tx_out in the cycle immediately after the accept edge.
//   - START -> DATA (1 cycle). DATA lasts DATA_WIDTH cycles, shifting right each edge.
//     A 3-bit counter wraps at DATA_WIDTH-1.
//   - After DATA: go to PARITY (1 cycle) if the latched Par_EN=1, else go to STOP.
//   - STOP lasts 1 cycle. Then IDLE, or START if a new request is accepted (back-to-back,
//     no idle gap).
//   - Parity: par_bit = ^data_latched when Par_TYP=0 (even);
//     par_bit = ~^data_latched when Par_TYP=1 (odd).
//     Computed from the latched byte, so it is unaffected by P_DATA changes mid-frame.
//   - Frame length: 11 cycles with parity, 10 cycles without.
//   - busy: 1 in START, DATA, PARITY, STOP; 0 in IDLE. Registered with the state.
//   - Changes to P_DATA, Par_EN or Par_TYP mid-frame do not affect the current frame.
//   - Reset asserted mid-frame aborts the frame immediately: Tx_out=1, busy=0.
// CONFIGURATION
//   UART_TX_TWO_STOP_EN defined: STOP lasts 2 cycles (two stop bits).
//     Back-to-back acceptance happens only in the 2nd stop cycle.
//     Frames are 12 cycles with parity, 11 without.
//   Macro undefined: a single stop bit as described above.
// TESTING
//   1. Reset: hold rst=0 for 2 cycles -> Tx_out=1, busy=0; stays idle with Data_Valid=0.
//   2. P_DATA=8'hDA, Par_EN=1, Par_TYP=1, one-cycle Data_Valid -> Tx_out sequence
//      0, 0,1,0,1,1,0,1,1, 0, 1 (start, data LSB first, odd parity=0, stop).
//      busy=1 for exactly those 11 cycles.
//   3. Back-to-back: assert Data_Valid during the stop bit of test 2 with 8'hDA, Par_EN=1,
//      Par_TYP=0 -> start bit follows with no idle gap; parity bit=1 (even).
//   4. P_DATA=8'hDA, Par_EN=0 (Par_TYP=0 and =1) -> 10-bit frame
//      0,0,1,0,1,1,0,1,1,1. Par_TYP has no effect.
//   5. Pulse Data_Valid with 8'h00 mid-frame -> ignored; current frame unchanged.
//      Change P_DATA mid-frame -> no effect.
//   6. Drive rst=0 during DATA -> Tx_out=1 and busy=0 immediately (async).
//      After release, the next request sends a complete, correct frame.
//      Repeat tests 2/4 with UART_TX_TWO_STOP_EN defined -> two 1s at frame end.

Source files
------------

// File: rtl/uart_tx_top.sv
// uart_tx_top: parallel-in, serial-out UART transmitter, one bit per clk.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
// Optional build macro UART_TX_TWO_STOP_EN: two stop bits per frame, with
// back-to-back acceptance only in the second stop cycle.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line idle (1), waiting for Data_Valid
// S_START  | start bit (0)
// S_DATA   | data bits, LSB first, shift register drains right
// S_PARITY | parity bit computed from the byte latched at accept
// S_STOP   | stop bit (1); a new request may be accepted here
module uart_tx_top #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  Par_EN,
    input  logic                  Par_TYP,
    output logic                  Tx_out,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_cnt_last;
    logic                  w_stop_last;

    assign w_cnt_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

`ifdef UART_TX_TWO_STOP_EN
    logic r_stop_second;

    // Marks the second of the two stop cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stop_second <= 1'b0;
        end else if (r_state == S_STOP) begin
            r_stop_second <= ~r_stop_second;
        end else begin
            r_stop_second <= 1'b0;
        end
    end

    assign w_stop_last = r_stop_second;
`else
    assign w_stop_last = 1'b1;
`endif

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and request acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Data_Valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START:  w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_cnt_last) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP: begin
                if (!w_stop_last) begin
                    w_state_nxt = S_STOP;
                end else if (Data_Valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the request on accept; shift and count while sending data bits.
    // Parity is folded at accept time so later P_DATA changes cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= P_DATA;
            r_cnt     <= '0;
            r_par_en  <= Par_EN;
            r_par_bit <= (^P_DATA) ^ Par_TYP;
        end else if (r_state == S_DATA) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_cnt   <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
    end

    // busy follows the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign busy = r_busy;

    // Serial line level decoded from the current state.
    always_comb begin
        Tx_out = 1'b1;
        case (r_state)
            S_IDLE:   Tx_out = 1'b1;
            S_START:  Tx_out = 1'b0;
            S_DATA:   Tx_out = r_shift[0];
            S_PARITY: Tx_out = r_par_bit;
            S_STOP:   Tx_out = 1'b1;
            default:  Tx_out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Testbench for uart_tx_top: table of frames with hand-computed bit sequences,
// plus reset, back-to-back, mid-frame request and async-reset-abort sequences.
// Honours UART_TX_TWO_STOP_EN by expecting one extra stop bit per frame.
module tb_uart_tx_top;

`ifdef UART_TX_TWO_STOP_EN
    localparam int XSTOP = 1;
`else
    localparam int XSTOP = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_EN;
    logic       Par_TYP;
    logic       Tx_out;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_top #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_EN     (Par_EN),
        .Par_TYP    (Par_TYP),
        .Tx_out     (Tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq is written in time order: leftmost bit is the first on the line.
    // Bits beyond the base length are stop/idle 1s.
    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        int         len;
        logic [0:11] seq;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        Par_EN     = pe;
        Par_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    // Checks len cycles starting in the current cycle; returns in the last one.
    task automatic check_bits(input string name, input logic [0:11] seq, input int len,
                              input int glitch_at);
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                tick();
                Data_Valid = 1'b0;
            end
            chk($sformatf("%s tx[%0d]", name, i), 32'(Tx_out), 32'(seq[i]));
            chk($sformatf("%s busy[%0d]", name, i), 32'(busy), 32'd1);
            if (i == glitch_at) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h00;
                Par_EN     = ~Par_EN;
                Par_TYP    = ~Par_TYP;
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " idle tx"}, 32'(Tx_out), 32'd1);
        chk({name, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{"DA_odd",  8'hDA, 1'b1, 1'b1, 11, 12'b0_01011011_0_1_1};
        vecs[1] = '{"DA_even", 8'hDA, 1'b1, 1'b0, 11, 12'b0_01011011_1_1_1};
        vecs[2] = '{"DA_np0",  8'hDA, 1'b0, 1'b0, 10, 12'b0_01011011_1_1_1};
        vecs[3] = '{"DA_np1",  8'hDA, 1'b0, 1'b1, 10, 12'b0_01011011_1_1_1};
        vecs[4] = '{"00_even", 8'h00, 1'b1, 1'b0, 11, 12'b0_00000000_0_1_1};
        vecs[5] = '{"FF_odd",  8'hFF, 1'b1, 1'b1, 11, 12'b0_11111111_1_1_1};
        vecs[6] = '{"01_even", 8'h01, 1'b1, 1'b0, 11, 12'b0_10000000_1_1_1};

        rst        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        Par_EN     = 1'b0;
        Par_TYP    = 1'b0;

        // Reset held for two cycles, then idle with no request.
        tick();
        tick();
        check_idle("reset");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("post_reset%0d", i));
        end

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            start_frame(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            check_bits(vecs[v].name, vecs[v].seq, vecs[v].len + XSTOP, -1);
            tick();
            check_idle(vecs[v].name);
            tick();
        end

        // Back-to-back: new request during the (last) stop bit, no idle gap.
        start_frame(8'hDA, 1'b1, 1'b1);
        check_bits("b2b_first", vecs[0].seq, 11 + XSTOP, -1);
        P_DATA     = 8'hDA;
        Par_EN     = 1'b1;
        Par_TYP    = 1'b0;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        check_bits("b2b_second", vecs[1].seq, 11 + XSTOP, -1);
        tick();
        check_idle("b2b");
        tick();

        // Request and input changes mid-frame are ignored.
        start_frame(8'hDA, 1'b1, 1'b1);
        check_bits("midframe", vecs[0].seq, 11 + XSTOP, 3);
        tick();
        check_idle("midframe");
        tick();

        // Async reset during DATA aborts the frame at once.
        start_frame(8'hDA, 1'b1, 1'b1);
        check_bits("abort_pre", vecs[0].seq, 4, -1);
        #2;
        rst = 1'b0;
        #1;
        check_idle("abort_async");
        tick();
        check_idle("abort_held");
        rst = 1'b1;
        tick();
        check_idle("abort_release");

        // Next request after the abort sends a complete, correct frame.
        start_frame(8'hDA, 1'b1, 1'b1);
        check_bits("after_abort", vecs[0].seq, 11 + XSTOP, -1);
        tick();
        check_idle("after_abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
